// File: rtl/hexkeypad.sv
// hexkeypad: scans a 4x4 hex membrane keypad one column at a time, debounces
// single-key presses over whole sweeps and shifts each accepted digit into a
// 32-bit value (newest digit in the low nibble) that can feed a hex display.
module hexkeypad #(
    parameter int SCAN_DIV = 5000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o,
    input  logic        clear_i,
    output logic [31:0] value_o,
    output logic [3:0]  key_o,
    output logic        key_valid_o,
    output logic [3:0]  digits_o
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Key code at (row, column) of the membrane layout.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            4'hF:    code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    col_o_q, col_o_d;
    logic [15:0]   map_q, map_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_q, key_d;
    logic          key_valid_q, key_valid_d;
    logic [31:0]   value_q, value_d;
    logic [3:0]    digits_q, digits_d;

    logic          last_dwell_s;
    logic          sweep_done_s;
    logic [15:0]   full_map_s;
    logic [4:0]    ones_s;
    logic [3:0]    hit_idx_s;
    logic          none_s;
    logic          single_s;
    logic [3:0]    hit_key_s;
    logic [CW-1:0] cnt_inc_s;
    logic          accept_s;
    logic [3:0]    accept_key_s;

    // Row synchroniser, column dwell timing and sweep-map accumulation.
    always_comb begin
        sync1_d      = row_i;
        sync2_d      = sync1_q;
        last_dwell_s = (dwell_q == DW'(SCAN_DIV - 1));
        sweep_done_s = last_dwell_s && (col_q == 2'd3);
        if (last_dwell_s) begin
            dwell_d = '0;
            col_d   = col_q + 2'd1;
        end else begin
            dwell_d = dwell_q + DW'(1);
            col_d   = col_q;
        end
        col_o_d    = ~(4'b0001 << col_d);
        full_map_s = map_q;
        case (col_q)
            2'd0:    full_map_s[3:0]   = ~sync2_q;
            2'd1:    full_map_s[7:4]   = ~sync2_q;
            2'd2:    full_map_s[11:8]  = ~sync2_q;
            2'd3:    full_map_s[15:12] = ~sync2_q;
            default: full_map_s        = map_q;
        endcase
        if (sweep_done_s) begin
            map_d = 16'h0000;
        end else if (last_dwell_s) begin
            map_d = full_map_s;
        end else begin
            map_d = map_q;
        end
    end

    // Classify the completed sweep map as none / single key / multiple keys.
    always_comb begin
        ones_s    = 5'd0;
        hit_idx_s = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (full_map_s[i]) begin
                ones_s    = ones_s + 5'd1;
                hit_idx_s = 4'(i);
            end else begin
                ones_s    = ones_s;
            end
        end
        none_s    = (ones_s == 5'd0);
        single_s  = (ones_s == 5'd1);
        // Map bit index is column*4 + row.
        hit_key_s = key_code(hit_idx_s[1:0], hit_idx_s[3:2]);
        cnt_inc_s = cnt_q + CW'(1);
    end

    // Debounce FSM next state, evaluated once per completed sweep.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cand_d       = cand_q;
        accept_s     = 1'b0;
        accept_key_s = cand_q;
        if (sweep_done_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (single_s) begin
                        cand_d = hit_key_s;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE == 1) begin
                            accept_s     = 1'b1;
                            accept_key_s = hit_key_s;
                            state_d      = ST_HELD;
                        end else begin
                            state_d = ST_PRESS;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESS: begin
                    if (single_s && (hit_key_s == cand_q)) begin
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s == CW'(DEBOUNCE)) begin
                            accept_s = 1'b1;
                            state_d  = ST_HELD;
                        end else begin
                            state_d = ST_PRESS;
                        end
                    end else if (single_s) begin
                        cand_d = hit_key_s;
                        cnt_d  = CW'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (none_s) begin
                        cnt_d = CW'(1);
                        if (DEBOUNCE == 1) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                ST_RELEASE: begin
                    if (none_s) begin
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s == CW'(DEBOUNCE)) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Accepted-key outputs and digit shift register; clear wins over store.
    always_comb begin
        key_valid_d = accept_s;
        key_d       = accept_s ? accept_key_s : key_q;
        if (clear_i) begin
            value_d  = 32'h0000_0000;
            digits_d = 4'd0;
        end else if (accept_s) begin
            value_d  = {value_q[27:0], accept_key_s};
            digits_d = (digits_q == 4'd8) ? 4'd8 : digits_q + 4'd1;
        end else begin
            value_d  = value_q;
            digits_d = digits_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 4'h0;
            sync2_q     <= 4'h0;
            dwell_q     <= '0;
            col_q       <= 2'd0;
            col_o_q     <= 4'b1110;
            map_q       <= 16'h0000;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'h0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            value_q     <= 32'h0000_0000;
            digits_q    <= 4'd0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            col_o_q     <= col_o_d;
            map_q       <= map_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            value_q     <= value_d;
            digits_q    <= digits_d;
        end
    end

    assign col_o       = col_o_q;
    assign value_o     = value_q;
    assign key_o       = key_q;
    assign key_valid_o = key_valid_q;
    assign digits_o    = digits_q;

endmodule

// File: tb/tb_hexkeypad.sv
// Directed bench for hexkeypad with a behavioural membrane keypad model.
module tb_hexkeypad;

    localparam int SD    = 4;
    localparam int DB    = 2;
    localparam int SWEEP = 4 * SD;

    // Row-major key layout: index = row*4 + col.
    localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                          4'h4, 4'h5, 4'h6, 4'hB,
                                          4'h7, 4'h8, 4'h9, 4'hC,
                                          4'hE, 4'h0, 4'hF, 4'hD};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic        clear_i = 1'b0;
    logic [31:0] value_o;
    logic [3:0]  key_o;
    logic        key_valid_o;
    logic [3:0]  digits_o;

    logic [15:0] pressed = 16'h0000;

    int          vectors = 0;
    int          miscompares = 0;
    int          pulses = 0;
    logic [3:0]  last_key = 4'h0;
    logic        prev_kv = 1'b0;

    typedef struct {
        logic [3:0]  key;
        logic [31:0] exp_value;
        logic [3:0]  exp_digits;
    } vec_t;

    vec_t tbl [9];

    hexkeypad #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .row_i       (row_i),
        .col_o       (col_o),
        .clear_i     (clear_i),
        .value_o     (value_o),
        .key_o       (key_o),
        .key_valid_o (key_valid_o),
        .digits_o    (digits_o)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
            end
        end
    end

    function automatic int key_pos(input logic [3:0] k);
        int p = 0;
        for (int i = 0; i < 16; i++) if (KEYMAP[i] == k) p = i;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Move to the negedge of the first cycle of column 0.
    task automatic align();
        logic [3:0] prev;
        bit found = 1'b0;
        @(negedge clk);
        prev = col_o;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && col_o == 4'b1110) found = 1'b1;
            prev = col_o;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL align: column 0 start not seen, col_o=%b", col_o);
        end
    endtask

    // Run n whole sweeps, counting key_valid pulses.
    task automatic run_sweeps(input int n);
        repeat (n * SWEEP) begin
            @(negedge clk);
            if (key_valid_o) begin
                pulses++;
                last_key = key_o;
                if (prev_kv) begin
                    miscompares++;
                    $display("FAIL kv_consecutive: got 1 expected 0");
                end
            end
            prev_kv = key_valid_o;
        end
    endtask

    // Press one key for 3 sweeps, release for 3, expect exactly one accept.
    task automatic press_key(input logic [3:0] k);
        align();
        pulses = 0;
        pressed = 16'h0000;
        pressed[key_pos(k)] = 1'b1;
        run_sweeps(3);
        pressed = 16'h0000;
        run_sweeps(3);
        check("press_pulses", 32'(pulses), 32'd1);
        check("press_key_o", {28'h0, last_key}, {28'h0, k});
    endtask

    initial begin
        tbl[0] = '{4'h1, 32'h0000_05A1, 4'd3};
        tbl[1] = '{4'h2, 32'h0000_5A12, 4'd4};
        tbl[2] = '{4'h3, 32'h0005_A123, 4'd5};
        tbl[3] = '{4'h4, 32'h005A_1234, 4'd6};
        tbl[4] = '{4'h5, 32'h05A1_2345, 4'd7};
        tbl[5] = '{4'h6, 32'h5A12_3456, 4'd8};
        tbl[6] = '{4'h7, 32'hA123_4567, 4'd8};
        tbl[7] = '{4'h8, 32'h1234_5678, 4'd8};
        tbl[8] = '{4'h9, 32'h2345_6789, 4'd8};

        // 1: reset values and column rotation
        repeat (3) @(negedge clk);
        check("rst_col", {28'h0, col_o}, 32'h0000_000E);
        check("rst_value", value_o, 32'h0);
        check("rst_digits", {28'h0, digits_o}, 32'h0);
        check("rst_kv", {31'h0, key_valid_o}, 32'h0);
        check("rst_key", {28'h0, key_o}, 32'h0);
        rst = 1'b0;
        repeat (SD) @(negedge clk);
        check("rot_col1", {28'h0, col_o}, 32'h0000_000D);
        repeat (SD) @(negedge clk);
        check("rot_col2", {28'h0, col_o}, 32'h0000_000B);
        repeat (SD) @(negedge clk);
        check("rot_col3", {28'h0, col_o}, 32'h0000_0007);
        repeat (SD) @(negedge clk);
        check("rot_col0", {28'h0, col_o}, 32'h0000_000E);

        // 2: long hold of '5' gives one accept; then 'A'
        align();
        pulses = 0;
        pressed = 16'h0000;
        pressed[key_pos(4'h5)] = 1'b1;
        run_sweeps(10);
        check("hold5_pulses", 32'(pulses), 32'd1);
        check("hold5_key", {28'h0, last_key}, 32'h5);
        check("hold5_value", value_o, 32'h0000_0005);
        check("hold5_digits", {28'h0, digits_o}, 32'd1);
        pressed = 16'h0000;
        run_sweeps(3);
        press_key(4'hA);
        check("a_value", value_o, 32'h0000_005A);
        check("a_digits", {28'h0, digits_o}, 32'd2);

        // 3: table of keys 1..9, saturating digit count and nibble drop
        for (int i = 0; i < 9; i++) begin
            press_key(tbl[i].key);
            check("tbl_value", value_o, tbl[i].exp_value);
            check("tbl_digits", {28'h0, digits_o}, {28'h0, tbl[i].exp_digits});
        end

        // 4: one-sweep bounces of '3' are never accepted
        align();
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            pressed = 16'h0000;
            pressed[key_pos(4'h3)] = 1'b1;
            run_sweeps(1);
            pressed = 16'h0000;
            run_sweeps(1);
        end
        check("bounce_pulses", 32'(pulses), 32'd0);
        check("bounce_value", value_o, 32'h2345_6789);

        // 5: two keys together rejected; '1' accepted 2 sweeps after '2' lifts
        align();
        pulses = 0;
        pressed = 16'h0000;
        pressed[key_pos(4'h1)] = 1'b1;
        pressed[key_pos(4'h2)] = 1'b1;
        run_sweeps(4);
        check("multi_pulses", 32'(pulses), 32'd0);
        pressed[key_pos(4'h2)] = 1'b0;
        run_sweeps(1);
        check("multi_early", 32'(pulses), 32'd0);
        run_sweeps(1);
        check("multi_late", 32'(pulses), 32'd1);
        check("multi_kv_now", {31'h0, key_valid_o}, 32'd1);
        check("multi_key", {28'h0, key_o}, 32'h1);
        check("multi_value", value_o, 32'h3456_7891);
        pressed = 16'h0000;
        run_sweeps(3);

        // 6: clear, then clear coinciding with the accept of 'F'
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check("clr_value", value_o, 32'h0);
        check("clr_digits", {28'h0, digits_o}, 32'd0);
        press_key(4'h1);
        press_key(4'h2);
        check("pre_value", value_o, 32'h0000_0012);
        check("pre_digits", {28'h0, digits_o}, 32'd2);
        align();
        pressed = 16'h0000;
        pressed[key_pos(4'hF)] = 1'b1;
        repeat (2 * SWEEP - 1) @(negedge clk);
        check("clracc_kv_before", {31'h0, key_valid_o}, 32'd0);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check("clracc_kv", {31'h0, key_valid_o}, 32'd1);
        check("clracc_key", {28'h0, key_o}, 32'hF);
        check("clracc_value", value_o, 32'h0);
        check("clracc_digits", {28'h0, digits_o}, 32'd0);
        @(negedge clk);
        check("clracc_kv_after", {31'h0, key_valid_o}, 32'd0);
        pressed = 16'h0000;
        run_sweeps(3);
        check("final_value", value_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hexkeypad.md
# hexkeypad

Scans a 4x4 hex membrane keypad and assembles pressed digits into a 32-bit value, one nibble per accepted key. Input-side counterpart of the eight-digit hex display path: the user types up to eight hex digits and `value_o` holds them in the same nibble order the display shows, so `value_o` can feed the display directly. The block includes column scanning, row synchronisation, single-key validation, debounce and a digit shift register.

## Interface
- `SCAN_DIV`, 5000: clock cycles each column is driven (100 µs at 50 MHz); legal minimum 4.
- `DEBOUNCE`, 4: consecutive identical full sweeps required to accept a press or a release; legal minimum 1.

Ports:
- `clk_i` input 1: the block's single clock.
- `rst_i` input 1: synchronous, active-high reset.
- `row_i` input 4: keypad rows; asynchronous, active-low, externally pulled up.
- `col_o` output 4: keypad columns; active-low, exactly one column low at any time.
- `clear_i` input 1: synchronous clear of the entered value.
- `value_o` output 32: entered digits; the newest digit is in [3:0].
- `key_o` output 4: code of the most recently accepted key.
- `key_valid_o` output 1: one-cycle pulse on each accepted key.
- `digits_o` output 4: number of digits entered, 0..8, saturating.

## Operation
- Key map (row r, column c), rows 0..3:
  - Row 0: 1 2 3 A.
  - Row 1: 4 5 6 B.
  - Row 2: 7 8 9 C.
  - Row 3: E(*) 0 F(#) D.
- Synchronisation: `row_i` passes through a 2-flop synchroniser. Only the synchronised rows are used.
- Scan:
  - A dwell counter counts 0..SCAN_DIV-1 for each column. The column index advances 0→1→2→3→0 when the counter wraps.
  - `col_o` = ~(1<<col).
  - On the last dwell cycle, the inverted synchronised rows are stored into the 4 bits of a 16-bit sweep map for that column.
  - After column 3 is sampled, the sweep is complete and the sweep map is classified:
    - NONE: no bits set.
    - SINGLE(k): exactly one bit set; k is that key's code.
    - MULTI: two or more bits set.
  - The sweep map is cleared for the next sweep.
- Debounce FSM, evaluated once per completed sweep:
  - IDLE:
    - SINGLE(k): latch candidate=k, cnt=1. If DEBOUNCE==1, accept; otherwise go to PRESS.
    - NONE or MULTI: stay in IDLE.
  - PRESS:
    - SINGLE(candidate): cnt++. When cnt reaches DEBOUNCE, accept and go to HELD.
    - SINGLE(other key): re-latch candidate to the new key, cnt=1.
    - NONE or MULTI: go to IDLE.
  - HELD:
    - NONE: cnt=1. If DEBOUNCE==1, go to IDLE; otherwise go to RELEASE.
    - SINGLE or MULTI: stay in HELD. There is no auto-repeat, and a second key is never accepted without a release first.
  - RELEASE:
    - NONE: cnt++. When cnt reaches DEBOUNCE, go to IDLE.
    - Anything else: go to HELD.
- Accept:
  - `key_o` ← candidate; `key_valid_o` pulses.
  - `value_o` ← {value_o[27:0], candidate}. The oldest nibble is discarded beyond 8 digits.
  - `digits_o` ← min(digits_o+1, 8).
- Clear:
  - `clear_i` sets `value_o`=0 and `digits_o`=0.
  - Clear has priority over an accept in the same cycle. In that case `key_o` and `key_valid_o` still report the key, but the key is not stored.
  - Clear does not affect the scan or the FSM.

## Timing
- Reset values:
  - `col_o`=4'b1110.
  - `value_o`=0, `key_o`=0, `key_valid_o`=0, `digits_o`=0.
  - FSM in IDLE; dwell counter, column index, sweep map, cnt and synchroniser all cleared.
- Reset mid-operation abandons any debounce in progress. A key still held after reset is re-accepted after DEBOUNCE clean sweeps.
- Full sweep length: 4*SCAN_DIV cycles.
- Acceptance latency: `key_valid_o`, `key_o`, `value_o` and `digits_o` all update on the cycle after the sampling edge of the DEBOUNCE-th matching sweep.
- Sampling: the synchroniser adds 2 cycles, which is why SCAN_DIV ≥ 4 is required. Row data settles within the dwell.
- `key_valid_o` is never high for two consecutive cycles. Minimum spacing between pulses is (2*DEBOUNCE)*4*SCAN_DIV cycles.
- `clear_i` takes effect on the next edge.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE=2. The bench keypad model drives row low while its column is low and its key is pressed.

1. Reset → `col_o`=1110, `value_o`=0, `digits_o`=0, `key_valid_o`=0; `col_o` rotates 1110→1101→1011→0111 every 4 cycles.
2. Hold key '5' (row 1, col 1) for 10 sweeps → exactly one `key_valid_o` pulse, `key_o`=5, `value_o`=0x00000005, `digits_o`=1. Release, then press 'A' → `value_o`=0x0000005A, `digits_o`=2.
3. Enter keys 1..9, with a release between each → `value_o`=0x23456789, `digits_o`=8.
4. Press key '3' for 1 sweep, release for 1 sweep, repeated 5 times → no `key_valid_o` pulse.
5. Hold '1' and '2' together for 4 sweeps → no pulse. Release '2' and keep '1' → `key_valid_o` pulses with `key_o`=1 exactly 2 sweeps later.
6. With `value_o`=0x12, assert `clear_i` on the accept cycle of key 'F' → `key_valid_o`=1, `key_o`=F, `value_o`=0, `digits_o`=0.
